fifo_ctrl: RTL

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_ptr.sv | 45 ++++
 rtl/fifo_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO controller slice: default geometry of the
// FIFO and the state encoding of the read sequencer.
// ----------------------------------------------------------------------------
package fifo_pkg;

    // Default geometry: DEPTH must always be 2**ADDR_WIDTH so that the
    // pointers wrap naturally by overflow.
    localparam int FIFO_ADDR_WIDTH = 8;
    localparam int FIFO_DATA_WIDTH = 10;
    localparam int FIFO_DEPTH      = 256;

    // Read sequencer states. A pop occupies IDLE (issue), RD_ISSUE and
    // RD_HOLD, so words come out at most once every three cycles.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_HOLD  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/fifo_ptr.sv
// ----------------------------------------------------------------------------
// fifo_ptr
// Wrapping ADDR_WIDTH-bit address pointer used for both the write and the
// read side of the FIFO. Wraps from 2**ADDR_WIDTH-1 back to 0 by overflow.
//
// Ports:
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low clear
//   inc_i   - advance the pointer by one at the next edge
//   ptr_o   - current pointer value
// ----------------------------------------------------------------------------
module fifo_ptr
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    // Next pointer value; overflow of the fixed-width add gives the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    // Pointer register with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// ----------------------------------------------------------------------------
// fifo_ctrl
// Controller for a FIFO built on an external single-port memory. Pushes are
// written in a single cycle while idle; a pop runs a three-cycle read
// sequence (issue, hold address, capture) and takes priority over a push.
//
// Ports:
//   clk_i        - clock, all state changes on the rising edge
//   rst_ni       - synchronous active-low reset
//   push_valid_i - write request
//   push_data_i  - write word
//   push_ready_o - a push is accepted this cycle when push_valid_i is high
//   pop_req_i    - level-sensitive read request
//   pop_valid_o  - one-cycle strobe marking pop_data_o valid
//   pop_data_o   - read word, held between strobes
//   full_o       - count_o == DEPTH
//   empty_o      - count_o == 0
//   count_o      - number of stored words
//   mem_addr_o   - memory address
//   mem_din_o    - memory write data
//   mem_en_o     - memory enable
//   mem_we_o     - memory write enable
//   mem_dout_i   - memory read data
// ----------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH,
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_valid_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    output logic                  push_ready_o,
    input  logic                  pop_req_i,
    output logic                  pop_valid_o,
    output logic [DATA_WIDTH-1:0] pop_data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i
);

    localparam logic [ADDR_WIDTH:0] DepthCount = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CountOne   = (ADDR_WIDTH+1)'(1);

    fifo_state_e           state_q;
    fifo_state_e           state_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  pop_valid_q;
    logic                  pop_valid_d;
    logic [DATA_WIDTH-1:0] pop_data_q;
    logic [DATA_WIDTH-1:0] pop_data_d;

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_inc;
    logic                  rd_inc;
    logic                  full;
    logic                  empty;

    assign full  = (count_q == DepthCount);
    assign empty = (count_q == '0);

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (wr_inc),
        .ptr_o  (wr_ptr)
    );

    fifo_ptr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (rd_inc),
        .ptr_o  (rd_ptr)
    );

    // Next-state and memory-port decode. The read address is held for all
    // three read cycles because the memory only presents valid data while
    // it is enabled for reading. Push and pop never complete on the same
    // edge (push only in IDLE, pop completes in RD_HOLD), so COUNT moves by
    // at most one per edge.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        pop_valid_d  = 1'b0;
        pop_data_d   = pop_data_q;
        wr_inc       = 1'b0;
        rd_inc       = 1'b0;
        push_ready_o = 1'b0;
        mem_en_o     = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        mem_din_o    = '0;

        unique case (state_q)
            IDLE: begin
                if (pop_req_i && !empty) begin
                    mem_en_o   = 1'b1;
                    mem_addr_o = rd_ptr;
                    state_d    = RD_ISSUE;
                end else if (!full) begin
                    push_ready_o = 1'b1;
                    if (push_valid_i) begin
                        mem_en_o   = 1'b1;
                        mem_we_o   = 1'b1;
                        mem_addr_o = wr_ptr;
                        mem_din_o  = push_data_i;
                        wr_inc     = 1'b1;
                        count_d    = count_q + CountOne;
                    end
                end
            end
            RD_ISSUE: begin
                mem_en_o   = 1'b1;
                mem_addr_o = rd_ptr;
                state_d    = RD_HOLD;
            end
            RD_HOLD: begin
                mem_en_o    = 1'b1;
                mem_addr_o  = rd_ptr;
                pop_data_d  = mem_dout_i;
                pop_valid_d = 1'b1;
                rd_inc      = 1'b1;
                count_d     = count_q - CountOne;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset silences the memory port and the handshake in the same cycle.
        if (!rst_ni) begin
            push_ready_o = 1'b0;
            mem_en_o     = 1'b0;
            mem_we_o     = 1'b0;
            wr_inc       = 1'b0;
            rd_inc       = 1'b0;
        end
    end

    // State, count and pop output registers. Reset abandons any read in
    // flight, so no pop strobe can follow a reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
        end
    end

    assign pop_valid_o = pop_valid_q;
    assign pop_data_o  = pop_data_q;
    assign count_o     = count_q;
    assign full_o      = full;
    assign empty_o     = empty;

endmodule
